// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the LSU formatting logic.
package memCtrlPkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } memStateT;

  localparam logic [31:0] DEFAULT_ADDR_ROM_1 = 32'h0010_0000;
  localparam logic [31:0] DEFAULT_ADDR_ROM_2 = 32'h0010_0004;

  function automatic logic sizeLegal(input logic [2:0] size);
    return size inside {SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU};
  endfunction

endpackage

// File: rtl/data_mem_arbiter_lsu_format.sv
// Combinational RISC-V load/store formatting: store byte lanes and data replication,
// load lane extraction with sign or zero extension.
module lsu_format
  import memCtrlPkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addrLow,
  input  logic [31:0] storeData,
  input  logic [31:0] loadWord,
  output logic [3:0]  byteSelect,
  output logic [31:0] storeWord,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    shifted = loadWord >> {addrLow, 3'b000};

    // The unsigned variants share the width encoding in the low two bits.
    case (size[1:0])
      2'b00: begin
        byteSelect = 4'b0001 << addrLow;
        storeWord  = {4{storeData[7:0]}};
      end
      2'b01: begin
        byteSelect = 4'b0011 << addrLow;
        storeWord  = {2{storeData[15:0]}};
      end
      default: begin
        byteSelect = 4'hF;
        storeWord  = storeData;
      end
    endcase

    case (size)
      SIZE_B:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      SIZE_BU: loadData = {24'h0, shifted[7:0]};
      SIZE_HU: loadData = {16'h0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and load/store sequencer in front of the synchronous
// data memory; one request per IDLE -> ACCESS -> RESP pass.
module data_mem_arbiter
  import memCtrlPkg::*;
#(
  parameter logic [31:0] ADDR_ROM_1 = DEFAULT_ADDR_ROM_1,
  parameter logic [31:0] ADDR_ROM_2 = DEFAULT_ADDR_ROM_2,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [1:0]  reqValid,
  output logic [1:0]  reqReady,
  input  logic [1:0]  reqWrite,
  input  logic [2:0]  reqSize0,
  input  logic [2:0]  reqSize1,
  input  logic [31:0] reqAddr0,
  input  logic [31:0] reqAddr1,
  input  logic [31:0] reqWdata0,
  input  logic [31:0] reqWdata1,
  output logic [1:0]  rspValid,
  output logic [31:0] rspData,
  output logic        rspError,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [3:0]  memReadByteSelect,
  output logic [3:0]  memWriteByteSelect,
  output logic [31:0] memAddress,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut,
  input  logic        memInvalidRead
);

  memStateT    state;
  logic        lastGrant;
  logic        grant;
  logic        writeQ;
  logic [2:0]  sizeQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;

  logic        sel;
  logic        misaligned;
  logic        decodeErr;
  logic        isRom;
  logic        outOfRange;
  logic        accessErr;
  logic [3:0]  fmtByteSel;
  logic [31:0] fmtStore;
  logic [31:0] fmtLoad;

  lsu_format uFormat (
    .size       (sizeQ),
    .addrLow    (addrQ[1:0]),
    .storeData  (wdataQ),
    .loadWord   (memDataOut),
    .byteSelect (fmtByteSel),
    .storeWord  (fmtStore),
    .loadData   (fmtLoad)
  );

  // On a tie the port that did not win last time is granted.
  always_comb begin
    sel      = (reqValid == 2'b11) ? ~lastGrant : reqValid[1];
    reqReady = 2'b00;
    if (resetN && state == IDLE && reqValid != 2'b00) begin
      reqReady[sel] = 1'b1;
    end
  end

  always_comb begin
    misaligned = ((sizeQ == SIZE_H || sizeQ == SIZE_HU) && addrQ[0]) ||
                 (sizeQ == SIZE_W && addrQ[1:0] != 2'b00);
    decodeErr  = !sizeLegal(sizeQ) || misaligned;
    isRom      = (addrQ == ADDR_ROM_1) || (addrQ == ADDR_ROM_2);
    outOfRange = memInvalidRead || ({2'b00, addrQ[31:2]} >= MEM_WORDS);
    // ROM words sit outside the array but remain readable.
    accessErr  = decodeErr || (writeQ ? outOfRange : (outOfRange && !isRom));
  end

  always_comb begin
    memReadEnable      = 1'b0;
    memWriteEnable     = 1'b0;
    memReadByteSelect  = 4'h0;
    memWriteByteSelect = 4'h0;
    memAddress         = 32'h0;
    memDataIn          = 32'h0;
    if (state == ACCESS) begin
      memAddress = addrQ;
      if (!decodeErr) begin
        if (writeQ) begin
          memWriteEnable     = 1'b1;
          memWriteByteSelect = fmtByteSel;
          memDataIn          = fmtStore;
        end else begin
          memReadEnable     = 1'b1;
          memReadByteSelect = 4'hF;
        end
      end
    end
  end

  always_comb begin
    rspData = 32'h0;
    if (state == RESP && rspValid != 2'b00 && !writeQ && !rspError) begin
      rspData = fmtLoad;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      grant     <= 1'b0;
      writeQ    <= 1'b0;
      sizeQ     <= 3'b000;
      addrQ     <= 32'h0;
      wdataQ    <= 32'h0;
      rspValid  <= 2'b00;
      rspError  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid != 2'b00) begin
            grant     <= sel;
            lastGrant <= sel;
            writeQ    <= reqWrite[sel];
            sizeQ     <= sel ? reqSize1 : reqSize0;
            addrQ     <= sel ? reqAddr1 : reqAddr0;
            wdataQ    <= sel ? reqWdata1 : reqWdata0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rspValid <= grant ? 2'b10 : 2'b01;
          rspError <= accessErr;
          state    <= RESP;
        end
        RESP: begin
          rspValid <= 2'b00;
          rspError <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: memory environment, byte-level reference model with
// per-cycle compare, directed literal checks and randomized two-port traffic.
module tb_data_mem_arbiter;
  import memCtrlPkg::*;

  localparam logic [31:0] ROM1      = 32'h0010_0000;
  localparam logic [31:0] ROM2      = 32'h0010_0004;
  localparam logic [31:0] ROM1_DATA = 32'h009D_8A0C;
  localparam logic [31:0] ROM2_DATA = 32'h0000_8067;
  localparam int unsigned WORDS     = 1024;
  localparam int unsigned BYTES     = WORDS * 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [1:0]  reqValid = 2'b00;
  logic [1:0]  reqReady;
  logic [1:0]  reqWrite = 2'b00;
  logic [2:0]  reqSize0 = 3'b0, reqSize1 = 3'b0;
  logic [31:0] reqAddr0 = 32'h0, reqAddr1 = 32'h0;
  logic [31:0] reqWdata0 = 32'h0, reqWdata1 = 32'h0;
  logic [1:0]  rspValid;
  logic [31:0] rspData;
  logic        rspError;
  logic        memReadEnable, memWriteEnable;
  logic [3:0]  memReadByteSelect, memWriteByteSelect;
  logic [31:0] memAddress, memDataIn;
  logic [31:0] memDataOut = 32'h0;
  logic        memInvalidRead;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_ROM_1 (ROM1),
    .ADDR_ROM_2 (ROM2),
    .MEM_WORDS  (WORDS)
  ) dut (
    .clk                (clk),
    .resetN             (resetN),
    .reqValid           (reqValid),
    .reqReady           (reqReady),
    .reqWrite           (reqWrite),
    .reqSize0           (reqSize0),
    .reqSize1           (reqSize1),
    .reqAddr0           (reqAddr0),
    .reqAddr1           (reqAddr1),
    .reqWdata0          (reqWdata0),
    .reqWdata1          (reqWdata1),
    .rspValid           (rspValid),
    .rspData            (rspData),
    .rspError           (rspError),
    .memReadEnable      (memReadEnable),
    .memWriteEnable     (memWriteEnable),
    .memReadByteSelect  (memReadByteSelect),
    .memWriteByteSelect (memWriteByteSelect),
    .memAddress         (memAddress),
    .memDataIn          (memDataIn),
    .memDataOut         (memDataOut),
    .memInvalidRead     (memInvalidRead)
  );

  // Synchronous data memory environment with two ROM words outside the array.
  bit [31:0] envMem [WORDS];
  assign memInvalidRead = (memAddress >= BYTES);

  always @(posedge clk) begin
    if (memReadEnable) begin
      if (memAddress == ROM1) memDataOut <= ROM1_DATA;
      else if (memAddress == ROM2) memDataOut <= ROM2_DATA;
      else if (!memInvalidRead) memDataOut <= envMem[memAddress[11:2]];
      else memDataOut <= 32'hDEAD_BEEF;
    end
    if (memWriteEnable && !memInvalidRead) begin
      for (int i = 0; i < 4; i++) begin
        if (memWriteByteSelect[i]) envMem[memAddress[11:2]][8*i +: 8] <= memDataIn[8*i +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory image plus per-request expectations.
  bit [7:0] refMem [BYTES];

  typedef struct {
    bit          g;
    bit          write;
    logic [31:0] addr;
    bit          decErr;
    bit          err;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] dataIn;
  } expT;

  function automatic logic [7:0] refByte(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] base;
    base = {a[31:2], 2'b00};
    if (base == ROM1) begin
      w = ROM1_DATA;
      return w[8*a[1:0] +: 8];
    end
    if (base == ROM2) begin
      w = ROM2_DATA;
      return w[8*a[1:0] +: 8];
    end
    if (a < BYTES) return refMem[a];
    return 8'h00;
  endfunction

  function automatic expT model(input bit g, input bit w, input logic [2:0] s,
                                input logic [31:0] a, input logic [31:0] d);
    expT e;
    int nb;
    bit legal, inRange, rom;
    logic [31:0] v;
    e.g = g; e.write = w; e.addr = a;
    e.err = 1'b0; e.data = 32'h0; e.sel = 4'h0; e.dataIn = 32'h0;
    legal   = (s == 3'd0 || s == 3'd1 || s == 3'd2 || s == 3'd4 || s == 3'd5);
    nb      = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
    e.decErr = !legal || (a % nb != 0);
    inRange = (a < BYTES);
    rom     = (a == ROM1) || (a == ROM2);
    if (e.decErr) begin
      e.err = 1'b1;
    end else if (w) begin
      e.err = !inRange;
      for (int i = 0; i < nb; i++) e.sel[(a + i) % 4] = 1'b1;
      for (int k = 0; k < 4; k++) e.dataIn[8*k +: 8] = d[8*(k % nb) +: 8];
    end else begin
      e.err = !inRange && !rom;
      if (!e.err) begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = refByte(a + i);
        if (!s[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!s[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.data = v;
      end
    end
    return e;
  endfunction

  // Per-cycle compare against the model.
  int   cyc = 0;
  bit   pend = 1'b0;
  int   hsCyc = 0;
  bit   modelLast = 1'b1;
  expT  ex;

  always @(negedge clk) begin
    logic [1:0] expReady;
    bit g;
    if (!resetN) begin
      pend      = 1'b0;
      modelLast = 1'b1;
    end else begin
      cyc++;
      expReady = 2'b00;
      if (!(pend && cyc <= hsCyc + 2) && reqValid != 2'b00) begin
        expReady = (reqValid == 2'b11) ? (modelLast ? 2'b01 : 2'b10) : reqValid;
      end
      check("reqReady", {30'h0, reqReady}, {30'h0, expReady});

      if (pend && cyc == hsCyc + 1) begin
        check("access memReadEnable", {31'h0, memReadEnable}, {31'h0, !ex.decErr && !ex.write});
        check("access memWriteEnable", {31'h0, memWriteEnable}, {31'h0, !ex.decErr && ex.write});
        check("access memReadByteSelect", {28'h0, memReadByteSelect},
              (!ex.decErr && !ex.write) ? 32'hF : 32'h0);
        check("access memWriteByteSelect", {28'h0, memWriteByteSelect}, {28'h0, ex.sel});
        check("access memAddress", memAddress, ex.addr);
        check("access memDataIn", memDataIn, ex.dataIn);
      end else begin
        check("idle mem controls", {22'h0, memReadEnable, memWriteEnable, memReadByteSelect,
              memWriteByteSelect}, 32'h0);
        check("idle memAddress", memAddress, 32'h0);
        check("idle memDataIn", memDataIn, 32'h0);
      end

      if (pend && cyc == hsCyc + 2) begin
        check("rspValid", {30'h0, rspValid}, ex.g ? 32'h2 : 32'h1);
        check("rspError", {31'h0, rspError}, {31'h0, ex.err});
        check("rspData", rspData, ex.data);
        if (ex.write && !ex.err) begin
          for (int i = 0; i < 4; i++) begin
            if (ex.sel[i]) refMem[{ex.addr[31:2], 2'b00} + i] = ex.dataIn[8*i +: 8];
          end
        end
        pend = 1'b0;
      end else begin
        check("quiet response", {29'h0, rspValid, rspError}, 32'h0);
        check("quiet rspData", rspData, 32'h0);
      end

      if (expReady != 2'b00) begin
        g = expReady[1];
        ex = model(g, reqWrite[g], g ? reqSize1 : reqSize0, g ? reqAddr1 : reqAddr0,
                   g ? reqWdata1 : reqWdata0);
        pend      = 1'b1;
        hsCyc     = cyc;
        modelLast = g;
      end
    end
  end

  task automatic setPort(input int p, input bit v, input bit w, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    reqValid[p] = v;
    reqWrite[p] = w;
    if (p == 0) begin
      reqSize0 = s; reqAddr0 = a; reqWdata0 = d;
    end else begin
      reqSize1 = s; reqAddr1 = a; reqWdata1 = d;
    end
  endtask

  // Returns #1 after the handshake edge, i.e. early in the ACCESS cycle.
  task automatic startReq(input int p, input bit w, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    bit ok;
    @(posedge clk); #1;
    setPort(p, 1'b1, w, s, a, d);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (reqReady[p]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    reqValid[p] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake port %0d: got no reqReady, required within 20 cycles", p);
    end
  endtask

  task automatic waitRsp(input int p, output logic [31:0] d, output logic e,
                         output logic [1:0] rv, output int lat);
    lat = 0; d = 32'h0; e = 1'b0; rv = 2'b00;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (rspValid[p]) begin
        lat = n; d = rspData; e = rspError; rv = rspValid;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL response port %0d: got none, required within 6 cycles", p);
    end
  endtask

  task automatic doReq(input string name, input int p, input bit w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] expData, input logic expErr);
    logic [31:0] rd;
    logic re;
    logic [1:0] rv;
    int lat;
    startReq(p, w, s, a, d);
    waitRsp(p, rd, re, rv, lat);
    if (lat != 0) begin
      check({name, " data"}, rd, expData);
      check({name, " error"}, {31'h0, re}, {31'h0, expErr});
    end
  endtask

  task automatic randomPort(input int p);
    bit v, w;
    logic [2:0] s;
    logic [31:0] a;
    int r;
    v = ($urandom % 10) < 6;
    w = $urandom % 2;
    r = $urandom % 16;
    if (r < 14) begin
      case ($urandom % (w ? 3 : 5))
        0: s = SIZE_B;
        1: s = SIZE_H;
        2: s = SIZE_W;
        3: s = SIZE_BU;
        default: s = SIZE_HU;
      endcase
    end else begin
      case ($urandom % 3)
        0: s = 3'b011;
        1: s = 3'b110;
        default: s = 3'b111;
      endcase
    end
    r = $urandom % 20;
    if (r == 0) a = ($urandom % 2) ? ROM1 : ROM2;
    else if (r == 1) a = 32'h0000_1000 + ($urandom % 64);
    else a = $urandom % 64;
    if (($urandom % 4) != 0) begin
      if (s[1:0] == 2'b01) a[0] = 1'b0;
      else if (s[1:0] == 2'b10) a[1:0] = 2'b00;
    end
    setPort(p, v, w, s, a, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic re;
    logic [1:0] rv;
    int lat;
    logic [1:0] grants [$];

    repeat (2) @(negedge clk);
    check("reset outputs", {15'h0, reqReady, rspValid, rspError, memReadEnable, memWriteEnable,
          memReadByteSelect, memWriteByteSelect}, 32'h0);
    check("reset memAddress", memAddress, 32'h0);
    #2 resetN = 1'b1;

    // Word store and load-back with latency.
    startReq(0, 1'b1, SIZE_W, 32'h10, 32'hCAFE_BABE);
    check("SW write select", {28'h0, memWriteByteSelect}, 32'hF);
    waitRsp(0, rd, re, rv, lat);
    check("SW error", {31'h0, re}, 32'h0);
    startReq(0, 1'b0, SIZE_W, 32'h10, 32'h0);
    waitRsp(0, rd, re, rv, lat);
    check("LW latency", lat, 2);
    check("LW rspValid", {30'h0, rv}, 32'h1);
    check("LW data", rd, 32'hCAFE_BABE);
    check("LW error", {31'h0, re}, 32'h0);

    // Byte store to the top lane, signed and unsigned reload.
    startReq(0, 1'b1, SIZE_B, 32'h13, 32'h0000_0080);
    check("SB write select", {28'h0, memWriteByteSelect}, 32'h8);
    check("SB memDataIn", memDataIn, 32'h8080_8080);
    waitRsp(0, rd, re, rv, lat);
    doReq("LB 0x13", 0, 1'b0, SIZE_B, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
    doReq("LBU 0x13", 1, 1'b0, SIZE_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0);

    // Misaligned and illegal-size decodes never enable the memory.
    startReq(0, 1'b0, SIZE_H, 32'h21, 32'h0);
    check("LH misaligned enables", {30'h0, memReadEnable, memWriteEnable}, 32'h0);
    waitRsp(0, rd, re, rv, lat);
    check("LH misaligned data", rd, 32'h0);
    check("LH misaligned error", {31'h0, re}, 32'h1);
    startReq(0, 1'b0, SIZE_W, 32'h22, 32'h0);
    check("LW misaligned enables", {30'h0, memReadEnable, memWriteEnable}, 32'h0);
    waitRsp(0, rd, re, rv, lat);
    check("LW misaligned error", {31'h0, re}, 32'h1);
    doReq("funct3 011", 1, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);

    // Address range boundaries.
    doReq("LW 0x1000", 0, 1'b0, SIZE_W, 32'h0000_1000, 32'h0, 32'h0, 1'b1);
    doReq("LW 0xFFC", 0, 1'b0, SIZE_W, 32'h0000_0FFC, 32'h0, 32'h0, 1'b0);
    doReq("LW ROM1", 0, 1'b0, SIZE_W, ROM1, 32'h0, 32'h009D_8A0C, 1'b0);
    doReq("SW ROM2", 1, 1'b1, SIZE_W, ROM2, 32'h1234_5678, 32'h0, 1'b1);

    // Reset during the ACCESS cycle of a store drops it.
    startReq(0, 1'b1, SIZE_W, 32'h30, 32'h1111_1111);
    check("pre-reset memWriteEnable", {31'h0, memWriteEnable}, 32'h1);
    #1 resetN = 1'b0;
    #1;
    check("in-reset outputs", {15'h0, reqReady, rspValid, rspError, memReadEnable,
          memWriteEnable, memReadByteSelect, memWriteByteSelect}, 32'h0);
    check("in-reset memAddress", memAddress, 32'h0);
    check("in-reset memDataIn", memDataIn, 32'h0);
    check("in-reset rspData", rspData, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("in-reset rspValid", {30'h0, rspValid}, 32'h0);
    end
    #2 resetN = 1'b1;

    // Both ports requesting continuously: grants alternate starting with port 0.
    @(posedge clk); #1;
    setPort(0, 1'b1, 1'b0, SIZE_W, 32'h10, 32'h0);
    setPort(1, 1'b1, 1'b0, SIZE_W, 32'h14, 32'h0);
    for (int n = 0; n < 40 && grants.size() < 6; n++) begin
      @(negedge clk);
      if (reqReady != 2'b00) grants.push_back(reqReady);
    end
    @(posedge clk); #1;
    reqValid = 2'b00;
    check("alternation grant count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) begin
      check("alternation grant", {30'h0, grants[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    repeat (3) @(negedge clk);

    doReq("LW dropped store", 0, 1'b0, SIZE_W, 32'h30, 32'h0, 32'h0, 1'b0);
    doReq("LH 0x12", 1, 1'b0, SIZE_H, 32'h12, 32'h0, 32'hFFFF_80FE, 1'b0);
    doReq("LHU 0x12", 0, 1'b0, SIZE_HU, 32'h12, 32'h0, 32'h0000_80FE, 1'b0);

    // Randomized two-port traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      randomPort(0);
      randomPort(1);
    end
    @(posedge clk); #1;
    reqValid = 2'b00;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Load/store sequencer and two-port arbiter in front of the synchronous dataMemory block.
- Port 0 is the core LSU; port 1 is the debug/loader port.
- Grants one request at a time and encodes RISC-V load/store sizes into memory byte selects and replicated write data.
- Aligns, sign-extends and zero-extends read data. Reports misaligned, illegal-size and out-of-range accesses as error responses.

Parameters:
- ADDR_ROM_1, 32'h00100000, address of special ROM word 0 (readable, not an error).
- ADDR_ROM_2, 32'h00100004, address of special ROM word 1 (readable, not an error).
- MEM_WORDS, 1024, data memory depth in 32-bit words.

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- reqValid  in  2  per-port request valid.
- reqReady  out  2  per-port accept; combinational, at most one bit set.
- reqWrite  in  2  per-port 1=store, 0=load.
- reqSize0, reqSize1  in  3 each  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- reqAddr0, reqAddr1  in  32 each  byte address.
- reqWdata0, reqWdata1  in  32 each  store data, LSB-justified.
- rspValid  out  2  one-cycle response pulse to the granted port; no backpressure.
- rspData  out  32  formatted load data; 0 for stores and errors.
- rspError  out  1  valid with rspValid.
- memReadEnable, memWriteEnable  out  1 each.
- memReadByteSelect, memWriteByteSelect  out  4 each.
- memAddress  out  32;  memDataIn  out  32.
- memDataOut  in  32;  memInvalidRead  in  1 (combinational, from memAddress).

Behaviour:
- Reset (async, resetN low): state IDLE, all outputs 0, lastGrant=1 so port 0 wins first. Any in-flight request is dropped with no response.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Throughput is one request per 3 cycles.
- IDLE:
  - If any reqValid, grant round-robin: the port not equal to lastGrant wins a tie; a single requester always wins.
  - reqReady[g]=1 in the same cycle.
  - Latch addr, size, write flag and wdata of g; update lastGrant=g; go to ACCESS.
- Decode of the latched request:
  - Illegal size: funct3 not in {000,001,010,100,101}.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- ACCESS:
  - memAddress=latched addr.
  - If illegal or misaligned: no enables; set errFlag.
  - Store:
    - memWriteEnable=1.
    - Byte select: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'hF.
    - memDataIn: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
    - errFlag=memInvalidRead.
  - Load:
    - memReadEnable=1, memReadByteSelect=4'hF.
    - errFlag=memInvalidRead && addr not in {ADDR_ROM_1, ADDR_ROM_2}.
  - Go to RESP.
- RESP:
  - rspValid[g]=1, rspError=errFlag.
  - Load without error: rspData = memDataOut>>(8*addr[1:0]); then B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged.
  - Go to IDLE.
- Latency: handshake at edge N, memory enable during cycle N+1, rspValid during cycle N+2.
- mem* outputs are 0 in IDLE and RESP. Enables never assert for an errored decode.
- Requests presented while busy wait; reqReady stays 0 and inputs need not be held stable before the handshake.
- rspData and rspError return to 0 when rspValid is low.

Decomposition:
- Shared package (memCtrlPkg):
  - size funct3 localparams (SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU);
  - state enum (IDLE, ACCESS, RESP);
  - ROM address constants.
- One natural sub-module, lsu_format: pure combinational store byte-select/data replication and load shift/extension, reusable by the core LSU.

Test Plan:
- Port 0 SW addr 0x10, wdata 0xCAFEBABE; then LW 0x10 -> memWriteByteSelect=4'hF during ACCESS; load rspValid=2'b01, rspData=0xCAFEBABE, rspError=0, exactly 2 cycles after the handshake.
- SB 0x13 data 0x80, then LB 0x13 and LBU 0x13 -> byte select 4'b1000, memDataIn=0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- Both ports valid continuously for 6 requests -> grants alternate 0,1,0,1,0,1; reqReady is never 2'b11.
- LH 0x21 and LW 0x22 -> no mem enables; rspError=1, rspData=0. funct3 011 -> also rspError=1.
- Boundary ranges:
  - LW 0x00001000 -> rspError=1.
  - LW ADDR_ROM_1 -> rspData=0x009D8A0C, rspError=0.
  - SW ADDR_ROM_2 -> rspError=1.
- resetN low during ACCESS of a store -> all outputs 0 immediately; no rspValid. After release, port 0 is granted first when both ports request.
